// File: rtl/fifo_drain_ctrl_if.sv
// Read-side bundle between fifo_drain_ctrl, the FIFO pop/read port and the
// downstream valid/ready sink. Signal names are from the controller's view.
interface fifo_drain_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              o_pop;
  logic              i_fifo_empty;
  logic [DATA_W-1:0] i_fifo_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  modport master (
    output o_pop, o_valid, o_data,
    input  i_fifo_empty, i_fifo_data, i_ready
  );

  modport slave (
    input  o_pop, o_valid, o_data,
    output i_fifo_empty, i_fifo_data, i_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// FIFO drain controller: pops the FIFO, absorbs its one-cycle read latency in
// a 2-entry buffer and presents words as a valid/ready stream. Runs a fixed
// burst (len != 0) or continuously until i_stop, then pulses o_done.
//
// state | meaning
// IDLE  | waiting for i_start; o_done may pulse here for one cycle
// RUN   | popping and delivering words
module fifo_drain_ctrl #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_burst_len,
  input  logic             i_stop,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_count,
  fifo_drain_ctrl_if.master bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [LEN_W-1:0]  pop_rem;
  logic [LEN_W-1:0]  out_rem;
  logic [LEN_W-1:0]  count;
  logic              continuous;
  logic              stop_flag;
  logic              inflight;
  logic              done_q;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic [1:0]        buf_count;

  logic              run;
  logic              fire;
  logic              pop;
  logic [2:0]        occ;

  // Occupancy after this cycle's fire; a pop is allowed only if the word it
  // brings in still has a buffer slot when it lands.
  assign run  = (state == S_RUN);
  assign fire = bus.o_valid & bus.i_ready;
  assign occ  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, fire};
  assign pop  = run & ~bus.i_fifo_empty & ~stop_flag &
                (continuous | (pop_rem != '0)) & (occ < 3'd2);

  assign bus.o_pop   = pop;
  assign bus.o_valid = (buf_count != 2'd0);
  assign bus.o_data  = buf0;
  assign o_busy      = run;
  assign o_done      = done_q;
  assign o_count     = count;

  // Sequencing: start/stop handling, remaining counters and completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pop_rem    <= '0;
      out_rem    <= '0;
      count      <= '0;
      continuous <= 1'b0;
      stop_flag  <= 1'b0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= pop;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_RUN;
            pop_rem    <= i_burst_len;
            out_rem    <= i_burst_len;
            count      <= '0;
            stop_flag  <= 1'b0;
            continuous <= (i_burst_len == '0);
          end
        end
        S_RUN: begin
          if (pop && !continuous)
            pop_rem <= pop_rem - 1'b1;
          if (fire) begin
            count <= count + 1'b1;
            if (!continuous)
              out_rem <= out_rem - 1'b1;
          end
          if (continuous && i_stop)
            stop_flag <= 1'b1;
          if (!continuous && fire && (out_rem == LEN_W'(1))) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else if (continuous && stop_flag && (buf_count == 2'd0) && !inflight) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry FIFO-ordered output buffer: tail write from the FIFO read data
  // the cycle after a pop, head read on fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0      <= '0;
      buf1      <= '0;
      buf_count <= 2'd0;
    end else begin
      case ({inflight, fire})
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf0 <= bus.i_fifo_data;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.i_fifo_data;
          end
        end
        2'b01: begin
          buf0      <= buf1;
          buf_count <= buf_count - 2'd1;
        end
        2'b10: begin
          if (buf_count == 2'd0)
            buf0 <= bus.i_fifo_data;
          else
            buf1 <= bus.i_fifo_data;
          buf_count <= buf_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO with registered read, expected
// words queued as they are pushed, and a monitor that checks every fire.
module tb_fifo_drain_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_burst_len;
  logic       i_stop;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_count;

  fifo_drain_ctrl_if #(.DATA_W(16)) bus ();

  fifo_drain_ctrl #(.DATA_W(16), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_burst_len (i_burst_len),
    .i_stop      (i_stop),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;
  int pops_total = 0;
  int fires_total = 0;
  int outstanding = 0;
  int cyc_idx = 0;
  bit tog_mode = 0;

  logic [15:0] fq[$];
  logic [15:0] expq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Advance to just after the next rising edge and apply the ready pattern.
  task automatic step();
    @(posedge clk);
    #1;
    cyc_idx++;
    if (tog_mode) bus.i_ready = ((cyc_idx % 3) == 1);
  endtask

  task automatic push_word(input logic [15:0] d);
    fq.push_back(d);
    expq.push_back(d);
    bus.i_fifo_empty = 1'b0;
  endtask

  task automatic flush();
    fq.delete();
    expq.delete();
    bus.i_fifo_empty = 1'b1;
  endtask

  task automatic start_op(input logic [7:0] len);
    i_start = 1'b1;
    i_burst_len = len;
    cyc_idx = 0;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // FIFO model: registered read data, one cycle after the pop.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        bus.i_fifo_data <= '0;
      end else if (bus.o_pop && fq.size() != 0) begin
        bus.i_fifo_data <= fq.pop_front();
        bus.i_fifo_empty <= (fq.size() == 0);
      end
    end
  end

  // Monitor: stream order, hold-while-stalled, pop legality.
  initial begin : monitor
    bit prev_stall;
    logic [15:0] prev_data;
    logic fire_now;
    logic [15:0] e;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        prev_stall = 1'b0;
      end else begin
        fire_now = bus.o_valid & bus.i_ready;
        if (prev_stall) begin
          chk("hold_valid", {31'd0, bus.o_valid}, 32'd1);
          chk("hold_data", {16'd0, bus.o_data}, {16'd0, prev_data});
        end
        if (bus.o_pop) begin
          chk("pop_not_empty", {31'd0, fq.size() != 0}, 32'd1);
          chk("pop_no_overflow", {31'd0, (outstanding + 1 - int'(fire_now)) <= 2}, 32'd1);
          pops_total++;
        end
        if (fire_now) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stream_extra: got word 0x%0h expected no transfer", bus.o_data);
          end else begin
            e = expq.pop_front();
            chk("stream_data", {16'd0, bus.o_data}, {16'd0, e});
          end
          fires_total++;
        end
        outstanding += int'(bus.o_pop) - int'(fire_now);
        prev_stall = bus.o_valid & ~bus.i_ready;
        prev_data = bus.o_data;
      end
    end
  end

  initial begin
    int p0;
    int f0;
    int p_at;
    bit ok;

    rst_n = 1'b0;
    i_start = 1'b0;
    i_burst_len = '0;
    i_stop = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_data = '0;
    step();
    step();
    flush();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pop", {31'd0, bus.o_pop}, 32'd0);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.o_data}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_count", {24'd0, o_count}, 32'd0);
    step();

    // Burst of 4, ready high: pops 1-4, valid 3-6, done 7.
    for (int i = 0; i < 4; i++) push_word(16'h00A0 + 16'(i));
    p0 = pops_total;
    start_op(8'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("b4_pop_c%0d", c), {31'd0, bus.o_pop}, {31'd0, c <= 4});
      chk($sformatf("b4_valid_c%0d", c), {31'd0, bus.o_valid}, {31'd0, (c >= 3) && (c <= 6)});
      chk($sformatf("b4_done_c%0d", c), {31'd0, o_done}, {31'd0, c == 7});
      if (c == 7) begin
        chk("b4_count", {24'd0, o_count}, 32'd4);
        chk("b4_busy_at_done", {31'd0, o_busy}, 32'd0);
      end
      step();
    end
    chk("b4_pops", p0 + 4, pops_total);

    // Burst of 6 with ready 1,0,0 repeating.
    for (int i = 0; i < 6; i++) push_word(16'h00B0 + 16'(i));
    p0 = pops_total;
    f0 = fires_total;
    tog_mode = 1'b1;
    start_op(8'd6);
    wait_done(80, ok);
    chk("b6_done_seen", {31'd0, ok}, 32'd1);
    chk("b6_count", {24'd0, o_count}, 32'd6);
    chk("b6_pops", pops_total - p0, 32'd6);
    chk("b6_fires", fires_total - f0, 32'd6);
    tog_mode = 1'b0;
    bus.i_ready = 1'b1;
    step();

    // Burst of 3 with one word available; the rest arrive 10 cycles later.
    push_word(16'h00C0);
    f0 = fires_total;
    start_op(8'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk("b3_stall_pop", {31'd0, bus.o_pop}, 32'd0);
      chk("b3_stall_busy", {31'd0, o_busy}, 32'd1);
    end
    step();
    push_word(16'h00C1);
    push_word(16'h00C2);
    wait_done(30, ok);
    chk("b3_done_seen", {31'd0, ok}, 32'd1);
    chk("b3_count", {24'd0, o_count}, 32'd3);
    chk("b3_fires", fires_total - f0, 32'd3);
    step();

    // Continuous mode: i_stop in the cycle after the 5th fire (cycle 8).
    for (int i = 0; i < 16; i++) push_word(16'(i));
    p0 = pops_total;
    f0 = fires_total;
    start_op(8'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (fires_total - f0 >= 5) break;
    end
    chk("cont_five_fires", fires_total - f0, 32'd5);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    p_at = pops_total;
    wait_done(40, ok);
    chk("cont_done_seen", {31'd0, ok}, 32'd1);
    chk("cont_pops_after_stop", pops_total, p_at);
    chk("cont_all_delivered", fires_total - f0, pops_total - p0);
    chk("cont_count_fires", {24'd0, o_count}, fires_total - f0);
    chk("cont_count", {24'd0, o_count}, 32'd8);
    step();
    rst_n = 1'b0;
    step();
    flush();
    rst_n = 1'b1;

    // Reset mid-burst while the buffer holds a word and another is in flight.
    for (int i = 0; i < 6; i++) push_word(16'h00D0 + 16'(i));
    bus.i_ready = 1'b0;
    start_op(8'd6);
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_full_no_pop", {31'd0, bus.o_pop}, 32'd0);
    chk("rm_valid_before", {31'd0, bus.o_valid}, 32'd1);
    step();
    flush();
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("rm_pop", {31'd0, bus.o_pop}, 32'd0);
    chk("rm_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rm_data", {16'd0, bus.o_data}, 32'd0);
    chk("rm_busy", {31'd0, o_busy}, 32'd0);
    chk("rm_count", {24'd0, o_count}, 32'd0);
    step();
    push_word(16'h00E8);
    push_word(16'h00E9);
    f0 = fires_total;
    start_op(8'd2);
    wait_done(20, ok);
    chk("rm2_done_seen", {31'd0, ok}, 32'd1);
    chk("rm2_count", {24'd0, o_count}, 32'd2);
    chk("rm2_fires", fires_total - f0, 32'd2);
    step();

    // i_start during RUN is ignored; i_start in the done cycle is taken.
    for (int i = 0; i < 3; i++) push_word(16'h00F0 + 16'(i));
    start_op(8'd3);
    step();
    i_start = 1'b1;
    i_burst_len = 8'd7;
    step();
    i_start = 1'b0;
    wait_done(20, ok);
    chk("rs_done_seen", {31'd0, ok}, 32'd1);
    chk("rs_count", {24'd0, o_count}, 32'd3);
    chk("rs_busy_at_done", {31'd0, o_busy}, 32'd0);
    push_word(16'h00F3);
    push_word(16'h00F4);
    start_op(8'd2);
    @(negedge clk);
    chk("rs_restart_busy", {31'd0, o_busy}, 32'd1);
    chk("rs_restart_count", {24'd0, o_count}, 32'd0);
    step();
    wait_done(20, ok);
    chk("rs2_done_seen", {31'd0, ok}, 32'd1);
    chk("rs2_count", {24'd0, o_count}, 32'd2);
    step();
    step();
    chk("leftover_expected", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
